// File: rtl/xpb_table_gen_pkg.sv
// xpb_gen_pkg: shared FSM encoding, size helpers and the reduce decision for xpb_table_gen. Rev 1.0
`default_nettype none
package xpb_gen_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_WR0  = 3'd1;
   localparam state_t ST_ADD  = 3'd2;
   localparam state_t ST_WR   = 3'd3;
   localparam state_t ST_FIN  = 3'd4;
   localparam state_t ST_CHK  = 3'd5;

   localparam int DEF_WIDTH   = 1024;
   localparam int DEF_IDX_W   = 5;
   localparam int DEF_DIGIT_W = 64;
   localparam int NDIG        = DEF_WIDTH / DEF_DIGIT_W;
   localparam int ENTRIES     = 2 ** DEF_IDX_W;

   function automatic int calc_ndig(input int width, input int digit_w);
      return width / digit_w;
   endfunction

   function automatic int calc_entries(input int idx_w);
      return 2 ** idx_w;
   endfunction

   // S >= M when the sum overflowed or S - M did not borrow.
   function automatic logic result_ge_m(input logic carry, input logic borrow);
      return carry | ~borrow;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xpb_digit_addsub.sv
// xpb_digit_addsub: one digit of a + b + cin and of (that sum) - m - bin, with carry/borrow out. Rev 1.0
`default_nettype none
module xpb_digit_addsub #(
   parameter int DIGIT_W = 64
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic [DIGIT_W-1:0] m,
   input  logic               carry_in,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] sum,
   output logic [DIGIT_W-1:0] diff,
   output logic               carry_out,
   output logic               borrow_out
);

   logic [DIGIT_W:0] s_full;
   logic [DIGIT_W:0] t_full;

   always_comb begin
      s_full = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, carry_in};
      // Top bit of the (DIGIT_W+1)-bit difference is the borrow out.
      t_full = {1'b0, s_full[DIGIT_W-1:0]} - {1'b0, m} - {{DIGIT_W{1'b0}}, borrow_in};
   end

   assign sum        = s_full[DIGIT_W-1:0];
   assign carry_out  = s_full[DIGIT_W];
   assign diff       = t_full[DIGIT_W-1:0];
   assign borrow_out = t_full[DIGIT_W];

endmodule
`default_nettype wire

// File: rtl/xpb_table_gen.sv
// xpb_table_gen: streams entry[i] = i*B mod M into a table RAM using digit-serial add/reduce. Rev 1.0
// Optional: XPB_TABLE_GEN_RANGE_CHECK_EN adds an err port and a B<M check state before the first write.
`default_nettype none
module xpb_table_gen
   import xpb_gen_pkg::*;
#(
   parameter int WIDTH   = 1024,
   parameter int IDX_W   = 5,
   parameter int DIGIT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] modulus_in,
   input  logic [WIDTH-1:0] base_in,
   output logic             busy,
   output logic             done,
   output logic             wr_valid,
   input  logic             wr_ready,
   output logic [IDX_W-1:0] wr_addr,
   output logic [WIDTH-1:0] wr_data
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
   ,output logic            err
`endif
);

   localparam int ND     = calc_ndig(WIDTH, DIGIT_W);
   localparam int DIG_CW = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(calc_entries(IDX_W) - 1);
   localparam logic [DIG_CW-1:0] LAST_DIG = DIG_CW'(ND - 1);

   state_t              state;
   logic [WIDTH-1:0]    modulus;
   logic [WIDTH-1:0]    base;
   logic [WIDTH-1:0]    acc;
   logic [WIDTH-1:0]    sum_sh;
   logic [WIDTH-1:0]    dif_sh;
   logic                carry;
   logic                borrow;
   logic [DIG_CW-1:0]   dig;
   logic [IDX_W-1:0]    idx;

   logic [DIGIT_W-1:0]  op_a;
   logic [DIGIT_W-1:0]  op_b;
   logic [DIGIT_W-1:0]  s_d;
   logic [DIGIT_W-1:0]  t_d;
   logic                cout;
   logic                bout;
   logic [WIDTH-1:0]    sum_next;
   logic [WIDTH-1:0]    dif_next;
   logic [WIDTH-1:0]    result;
   logic                dig_last;
   logic                hs;

   // Operands rotate right one digit per cycle, so digit 0 is always the live slice.
   function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
      return (ND == 1) ? x : ((x >> DIGIT_W) | (x << (WIDTH - DIGIT_W)));
   endfunction

   always_comb begin
      op_a = acc[DIGIT_W-1:0];
      op_b = base[DIGIT_W-1:0];
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      if (state == ST_CHK) begin
         op_a = base[DIGIT_W-1:0];
         op_b = '0;
      end
`endif
   end

   xpb_digit_addsub #(.DIGIT_W(DIGIT_W)) u_addsub (
      .a          (op_a),
      .b          (op_b),
      .m          (modulus[DIGIT_W-1:0]),
      .carry_in   (carry),
      .borrow_in  (borrow),
      .sum        (s_d),
      .diff       (t_d),
      .carry_out  (cout),
      .borrow_out (bout)
   );

   assign sum_next = (sum_sh >> DIGIT_W) | (WIDTH'(s_d) << (WIDTH - DIGIT_W));
   assign dif_next = (dif_sh >> DIGIT_W) | (WIDTH'(t_d) << (WIDTH - DIGIT_W));
   assign result   = result_ge_m(cout, bout) ? dif_next : sum_next;
   assign dig_last = (dig == LAST_DIG);
   assign hs       = wr_valid & wr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         modulus  <= '0;
         base     <= '0;
         acc      <= '0;
         sum_sh   <= '0;
         dif_sh   <= '0;
         carry    <= 1'b0;
         borrow   <= 1'b0;
         dig      <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
         err  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (start) begin
                  modulus <= modulus_in;
                  base    <= base_in;
                  acc     <= '0;
                  idx     <= '0;
                  dig     <= '0;
                  carry   <= 1'b0;
                  borrow  <= 1'b0;
                  busy    <= 1'b1;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
                  state   <= ST_CHK;
`else
                  state    <= ST_WR0;
                  wr_valid <= 1'b1;
                  wr_addr  <= '0;
                  wr_data  <= '0;
`endif
               end
            end
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
            ST_CHK: begin
               modulus <= rot(modulus);
               base    <= rot(base);
               borrow  <= bout;
               dig     <= dig + 1'b1;
               if (dig_last) begin
                  dig    <= '0;
                  carry  <= 1'b0;
                  borrow <= 1'b0;
                  if (!bout) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_FIN;
                  end else begin
                     state    <= ST_WR0;
                     wr_valid <= 1'b1;
                     wr_addr  <= '0;
                     wr_data  <= '0;
                  end
               end
            end
`endif
            ST_WR0: begin
               if (hs) begin
                  wr_valid <= 1'b0;
                  idx      <= IDX_W'(1);
                  state    <= ST_ADD;
               end
            end
            ST_ADD: begin
               acc     <= rot(acc);
               base    <= rot(base);
               modulus <= rot(modulus);
               sum_sh  <= sum_next;
               dif_sh  <= dif_next;
               carry   <= cout;
               borrow  <= bout;
               dig     <= dig + 1'b1;
               if (dig_last) begin
                  dig      <= '0;
                  carry    <= 1'b0;
                  borrow   <= 1'b0;
                  acc      <= result;
                  wr_data  <= result;
                  wr_addr  <= idx;
                  wr_valid <= 1'b1;
                  state    <= ST_WR;
               end
            end
            ST_WR: begin
               if (hs) begin
                  wr_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_FIN;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_ADD;
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: checks a 16-bit/4-bit-digit and a default-size xpb_table_gen against i*B mod M.
`default_nettype none
module tb_xpb_table_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   sel = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic         s_start, s_busy, s_done, s_valid, s_ready;
   logic [15:0]  s_mod, s_base, s_data;
   logic [4:0]   s_addr;
   logic         b_start, b_busy, b_done, b_valid, b_ready;
   logic [1023:0] b_mod, b_base, b_data;
   logic [4:0]   b_addr;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
   logic         s_err, b_err, cur_err;
   localparam int CHK_SMALL = 4;
   localparam int CHK_BIG   = 16;
`else
   localparam int CHK_SMALL = 0;
   localparam int CHK_BIG   = 0;
`endif

   xpb_table_gen #(.WIDTH(16), .IDX_W(5), .DIGIT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .modulus_in(s_mod), .base_in(s_base),
      .busy(s_busy), .done(s_done), .wr_valid(s_valid), .wr_ready(s_ready),
      .wr_addr(s_addr), .wr_data(s_data)
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      , .err(s_err)
`endif
   );

   xpb_table_gen u_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .modulus_in(b_mod), .base_in(b_base),
      .busy(b_busy), .done(b_done), .wr_valid(b_valid), .wr_ready(b_ready),
      .wr_addr(b_addr), .wr_data(b_data)
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      , .err(b_err)
`endif
   );

   logic          cur_valid, cur_done, cur_busy;
   logic [4:0]    cur_addr;
   logic [1023:0] cur_data;

   always_comb begin
      cur_valid = (sel != 0) ? b_valid : s_valid;
      cur_done  = (sel != 0) ? b_done  : s_done;
      cur_busy  = (sel != 0) ? b_busy  : s_busy;
      cur_addr  = (sel != 0) ? b_addr  : s_addr;
      cur_data  = (sel != 0) ? b_data  : 1024'(s_data);
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      cur_err   = (sel != 0) ? b_err   : s_err;
`endif
   end

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain wide multiply and modulo.
   function automatic logic [1023:0] xpb_ref(input int i, input logic [1023:0] m, input logic [1023:0] b);
      logic [1039:0] p;
      p = 1040'(i) * {16'd0, b};
      p = p % {16'd0, m};
      return p[1023:0];
   endfunction

   task automatic drive_start(input int big, input logic [1023:0] m, input logic [1023:0] b);
      if (big != 0) begin
         b_mod = m; b_base = b; b_start = 1'b1;
      end else begin
         s_mod = m[15:0]; s_base = b[15:0]; s_start = 1'b1;
      end
   endtask

   task automatic run_table(input int big, input logic [1023:0] m, input logic [1023:0] b,
                            input int stall_idx, input int stall_len, input int inj_idx,
                            input int rst_idx, input int chk_lat);
      int nd, k, n, exp_idx, last_hs, stalled, done_cnt, limit, inj_state, st_i;
      logic [1023:0] held_data;
      logic [4:0]    held_addr;
      bit aborted;
      nd = (big != 0) ? 16 : 4;
      sel = big;
      limit = 2 + 32 * (nd + 1) + stall_len + 40;
      exp_idx = 0; stalled = 0; done_cnt = 0; inj_state = 0; aborted = 0;
      last_hs = ((big != 0) ? CHK_BIG : CHK_SMALL);
      held_data = '0; held_addr = '0;
      @(negedge clk);
      drive_start(big, m, b);
      k = cyc;
      n = 0;
      while (done_cnt == 0 && !aborted && n < limit) begin
         @(negedge clk);
         n = cyc - k;
         s_start = 1'b0; b_start = 1'b0;
         s_ready = 1'b1; b_ready = 1'b1;
         if (inj_state == 1) begin
            drive_start(big, ~m, m);
            inj_state = 2;
         end
         if (cur_done) begin
            done_cnt++;
            check("done_cycle", 1024'(n), 1024'(last_hs + 1));
            check("entries_written", 1024'(exp_idx), 1024'(32));
            if (chk_lat != 0)
               check("done_latency", 1024'(n), 1024'(2 + 31 * (nd + 1) + ((big != 0) ? CHK_BIG : CHK_SMALL)));
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
            check("err_low", 1024'(cur_err), 1024'(0));
`endif
         end else if (cur_valid) begin
            if (rst_idx >= 0 && int'(cur_addr) == rst_idx) begin
               s_ready = 1'b0; b_ready = 1'b0;
               #1 rst_n = 1'b0;
               #1;
               check("rst_busy", 1024'(cur_busy), 1024'(0));
               check("rst_valid", 1024'(cur_valid), 1024'(0));
               aborted = 1;
               @(negedge clk);
               rst_n = 1'b1;
            end else if (int'(cur_addr) == stall_idx && stalled < stall_len) begin
               s_ready = 1'b0; b_ready = 1'b0;
               if (stalled == 0) begin
                  held_addr = cur_addr;
                  held_data = cur_data;
               end else begin
                  check("stall_addr", 1024'(cur_addr), 1024'(held_addr));
                  check("stall_data", cur_data, held_data);
               end
               stalled++;
            end else begin
               st_i = (exp_idx == stall_idx) ? stall_len : 0;
               check("addr", 1024'(cur_addr), 1024'(exp_idx));
               check("data", cur_data, xpb_ref(exp_idx, m, b));
               check("busy", 1024'(cur_busy), 1024'(1));
               check("hs_cycle", 1024'(n), 1024'(last_hs + ((exp_idx == 0) ? 1 : nd + 1) + st_i));
               last_hs = n;
               if (exp_idx == inj_idx) inj_state = 1;
               exp_idx++;
            end
         end
      end
      s_start = 1'b0; b_start = 1'b0;
      s_ready = 1'b1; b_ready = 1'b1;
      if (!aborted) begin
         repeat (3) begin
            @(negedge clk);
            if (cur_done) done_cnt++;
            check("idle_valid", 1024'(cur_valid), 1024'(0));
         end
         check("done_pulses", 1024'(done_cnt), 1024'(1));
         check("busy_after", 1024'(cur_busy), 1024'(0));
      end
   endtask

`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
   task automatic run_err(input logic [15:0] m, input logic [15:0] b);
      int writes, dones;
      writes = 0; dones = 0;
      sel = 0;
      @(negedge clk);
      drive_start(0, 1024'(m), 1024'(b));
      repeat (30) begin
         @(negedge clk);
         s_start = 1'b0;
         if (cur_valid) writes++;
         if (cur_done) begin
            dones++;
            check("err_with_done", 1024'(cur_err), 1024'(1));
         end
      end
      check("err_writes", 1024'(writes), 1024'(0));
      check("err_dones", 1024'(dones), 1024'(1));
      check("err_cleared", 1024'(cur_err), 1024'(0));
   endtask
`endif

   initial begin
      logic [1023:0] bm, bb;
      logic [15:0]   sm, sb;
      s_start = 1'b0; s_mod = '0; s_base = '0; s_ready = 1'b1;
      b_start = 1'b0; b_mod = '0; b_base = '0; b_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         sel = d;
         #1;
         check("rst_busy0", 1024'(cur_busy), 1024'(0));
         check("rst_done0", 1024'(cur_done), 1024'(0));
         check("rst_valid0", 1024'(cur_valid), 1024'(0));
         check("rst_addr0", 1024'(cur_addr), 1024'(0));
         check("rst_data0", cur_data, 1024'(0));
      end
      rst_n = 1'b1;

      run_table(0, 1024'(16'hFFF1), 1024'(16'h1000), -1, 0, -1, -1, 1);
      run_table(0, 1024'(16'hFFF1), 1024'(16'hFFF0), -1, 0, -1, -1, 1);
      run_table(0, 1024'(16'hFFF1), 1024'(16'h1000), 3, 7, -1, -1, 0);
      run_table(0, 1024'(16'hFFF1), 1024'(16'h1234), -1, 0, 2, 10, 0);
      run_table(0, 1024'(16'hFFF1), 1024'(16'h1234), -1, 0, -1, -1, 1);
      for (int r = 0; r < 4; r++) begin
         sm = 16'($urandom_range(2, 65535));
         sb = 16'($urandom_range(0, int'(sm) - 1));
         run_table(0, 1024'(sm), 1024'(sb), int'($urandom_range(0, 31)), int'($urandom_range(1, 5)), -1, -1, 0);
      end

      bm = '0; bm[1023] = 1'b1; bm[0] = 1'b1;
      bb = '0; bb[0] = 1'b1;
      run_table(1, bm, bb, -1, 0, -1, -1, 1);
      for (int w = 0; w < 32; w++) begin
         bm[w*32 +: 32] = $urandom;
         bb[w*32 +: 32] = $urandom;
      end
      bm[1023] = 1'b1;
      bb = bb % bm;
      run_table(1, bm, bb, int'($urandom_range(0, 31)), 3, -1, -1, 0);

`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      run_err(16'hFFF1, 16'hFFF1);
      run_err(16'h1234, 16'hF000);
      run_table(0, 1024'(16'hFFF1), 1024'(16'hFFF0), -1, 0, -1, -1, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
